btb_update_ctrl: RTL and testbench
==================================

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, update-queue entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ex_valid  input  1  resolved branch/jump presented by EX.
REQ-005 SHALL have port ex_pc  input  32  PC of resolved instruction.
REQ-006 SHALL have port ex_target  input  32  computed branch target.
REQ-007 SHALL have port ex_taken  input  1  branch resolved taken.
REQ-008 SHALL have port ex_pred_hit  input  1  BTB hit recorded at fetch.
REQ-009 SHALL have port ex_pred_pc  input  32  BTB predicted PC recorded at fetch.
REQ-010 SHALL have port ex_ready  output  1  resolution accepted this cycle.
REQ-011 SHALL have port btb_wr_block  input  1  BTB write port unavailable.
REQ-012 SHALL have port btb_load  output  1  BTB write strobe.
REQ-013 SHALL have port btb_pc  output  32  BTB write PC (index/tag source).
REQ-014 SHALL have port btb_target  output  32  BTB write target.
REQ-015 SHALL have port redirect  output  1  one-cycle fetch redirect pulse.
REQ-016 SHALL have port redirect_pc  output  32  corrected fetch PC.

Function
REQ-017 SHALL accept a resolution when ex_valid && ex_ready; ex_ready = !full.
REQ-018 SHALL flag mispredict when (ex_taken && (!ex_pred_hit || ex_pred_pc != ex_target)) or (!ex_taken && ex_pred_hit).
REQ-019 SHALL assert redirect the cycle after an accepted mispredict, for one cycle; redirect_pc = ex_target if taken, else ex_pc + 4 (mod 2^32).
REQ-020 SHALL enqueue {ex_pc, ex_target} only for accepted taken mispredicts; correct predictions and not-taken resolutions write nothing.
REQ-021 SHALL coalesce: if a queued entry other than one popping this cycle has the same ex_pc, overwrite its target in place; no new entry, count unchanged.
REQ-022 SHALL run FSM IDLE (empty), DRAIN (non-empty, !btb_wr_block), STALL (non-empty, btb_wr_block), re-evaluated from next-cycle count and btb_wr_block each edge.
REQ-023 SHALL assert btb_load only in DRAIN while btb_wr_block = 0, driving btb_pc/btb_target from queue head, and pop head that cycle.
REQ-024 SHALL allow push and pop in the same cycle when not full; count unchanged, FIFO order preserved.
REQ-025 SHALL not accept when full even if a pop occurs that cycle.
REQ-026 SHALL wrap read/write pointers modulo DEPTH.
REQ-027 SHALL hold btb_pc/btb_target at 0 when btb_load = 0.

Reset
REQ-028 SHALL, on rst_n low at any time, empty queue, enter IDLE, drop pending redirect; all outputs 0 except ex_ready = 1.
REQ-029 SHALL begin accepting on the first rising clk after rst_n rises.

Configuration
REQ-030 SHALL, with BTB_STATS_EN defined, add outputs branch_count 32 and mispredict_count 32, incrementing per accepted resolution / accepted mispredict, saturating at all-ones, cleared by reset.
REQ-031 SHALL, without BTB_STATS_EN, omit those ports and counters entirely.

Structure
REQ-032 SHALL place typedef btb_upd_t {pc, target} and the DEPTH default in rv32i_types; use rv32i_word for all 32-bit fields.
REQ-033 SHALL implement the queue as sub-module btb_upd_fifo (push, pop, coalesce-write, head, full, empty).

Verification
REQ-034 SHALL cover: taken, pred_hit=0, pc 0x100, target 0x200 -> redirect to 0x200 next cycle; btb_load with 0x100/0x200 following cycle.
REQ-035 SHALL cover: not taken, pred_hit=1, pc 0x300 -> redirect to 0x304; no btb_load.
REQ-036 SHALL cover: btb_wr_block=1, 4 taken mispredicts to distinct PCs -> ex_ready=0 on 5th; unblock -> 4 in-order btb_load pulses.
REQ-037 SHALL cover: two mispredicts pc 0x400 targets 0x500 then 0x600 while blocked -> one entry, single btb_load target 0x600.
REQ-038 SHALL cover: reset asserted mid-drain with 3 entries -> btb_load and redirect 0 immediately, IDLE, ex_ready=1.
REQ-039 SHALL cover, with BTB_STATS_EN: 10 resolutions, 3 mispredicts -> branch_count 10, mispredict_count 3.

Source files
------------

// File: rtl/btb_update_ctrl_pkg.sv
// rv32i_types: shared word/BTB-update types, queue depth default and mispredict rule
// for btb_update_ctrl (optional BTB_STATS_EN counters live in the top).
package rv32i_types;
  typedef logic [31:0] rv32i_word;
  typedef struct packed {
    rv32i_word pc;
    rv32i_word target;
  } btb_upd_t;
  localparam int BTB_UPD_DEPTH = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_STALL} btb_upd_state_e;
  function automatic logic is_mispredict(input logic taken, input logic hit,
                                         input rv32i_word pred_pc, input rv32i_word target);
    return taken ? (!hit || pred_pc != target) : hit;
  endfunction
endpackage

// File: rtl/btb_update_ctrl_fifo.sv
// btb_upd_fifo: BTB update queue with push, pop and coalescing of same-PC writes.
// A push whose PC matches a live entry (other than the one leaving) rewrites that target.
module btb_upd_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = BTB_UPD_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  btb_upd_t                   i_data,
  output btb_upd_t                   o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count_nxt
);
  localparam int AW = $clog2(DEPTH);
  btb_upd_t       r_mem [DEPTH];
  logic [AW-1:0]  r_rd;
  logic [AW-1:0]  r_wr;
  logic [AW:0]    r_cnt;
  logic           w_hit;
  logic [AW-1:0]  w_hit_idx;
  logic           w_push;
  logic           w_upd;
  always_comb begin
    logic [AW-1:0] off;
    w_hit = 1'b0;
    w_hit_idx = '0;
    off = '0;
    for (int j = 0; j < DEPTH; j++) begin
      off = AW'(j) - r_rd;
      if ({1'b0, off} < r_cnt && !(off == '0 && i_pop) && r_mem[j].pc == i_data.pc) begin
        w_hit = 1'b1;
        w_hit_idx = AW'(j);
      end
    end
  end
  assign w_push      = i_push && !w_hit;
  assign w_upd       = i_push && w_hit;
  assign o_count_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(i_pop);
  assign o_full      = r_cnt == (AW+1)'(DEPTH);
  assign o_empty     = r_cnt == '0;
  assign o_head      = r_mem[r_rd];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      r_rd  <= r_rd + AW'(i_pop);
      r_wr  <= r_wr + AW'(w_push);
      r_cnt <= o_count_nxt;
    end
  end
  // Storage needs no reset: entries are only observed while counted live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
    if (w_upd) r_mem[w_hit_idx].target <= i_data.target;
  end
endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: queues BTB corrections from EX, drains them to the BTB write port
// and pulses a fetch redirect on mispredict. Define BTB_STATS_EN for branch/mispredict counters.
module btb_update_ctrl
  import rv32i_types::*;
#(
  parameter int DEPTH = BTB_UPD_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      ex_valid,
  input  rv32i_word ex_pc,
  input  rv32i_word ex_target,
  input  logic      ex_taken,
  input  logic      ex_pred_hit,
  input  rv32i_word ex_pred_pc,
  output logic      ex_ready,
  input  logic      btb_wr_block,
  output logic      btb_load,
  output rv32i_word btb_pc,
  output rv32i_word btb_target,
  output logic      redirect,
`ifdef BTB_STATS_EN
  output rv32i_word redirect_pc,
  output rv32i_word branch_count,
  output rv32i_word mispredict_count
`else
  output rv32i_word redirect_pc
`endif
);
  btb_upd_state_e            r_state;
  logic                      r_redirect;
  rv32i_word                 r_redirect_pc;
  logic                      w_accept;
  logic                      w_mispred;
  logic                      w_push;
  logic                      w_full;
  logic                      w_empty;
  btb_upd_t                  w_head;
  logic [$clog2(DEPTH):0]    w_count_nxt;
  assign ex_ready    = !w_full;
  assign w_accept    = ex_valid && ex_ready;
  assign w_mispred   = is_mispredict(ex_taken, ex_pred_hit, ex_pred_pc, ex_target);
  assign w_push      = w_accept && ex_taken && w_mispred;
  assign btb_load    = r_state == ST_DRAIN && !btb_wr_block;
  assign btb_pc      = btb_load ? w_head.pc : '0;
  assign btb_target  = btb_load ? w_head.target : '0;
  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
  btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_pop       (btb_load),
    .i_data      ('{pc: ex_pc, target: ex_target}),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count_nxt (w_count_nxt)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_state       <= w_count_nxt == '0 ? ST_IDLE : btb_wr_block ? ST_STALL : ST_DRAIN;
      r_redirect    <= w_accept && w_mispred;
      r_redirect_pc <= !(w_accept && w_mispred) ? '0 : ex_taken ? ex_target : ex_pc + 32'd4;
    end
  end
`ifdef BTB_STATS_EN
  rv32i_word r_branch_count;
  rv32i_word r_mispredict_count;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_accept && !(&r_branch_count)) r_branch_count <= r_branch_count + 32'd1;
      if (w_accept && w_mispred && !(&r_mispredict_count)) r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: directed + random stimulus against a queue-based reference model.
// Define BTB_STATS_EN to also check the statistics counters.
module tb_btb_update_ctrl;
  localparam int DEPTH = 4;
  typedef struct {logic [31:0] pc; logic [31:0] tgt;} ent_t;
  logic clk = 0, rst_n = 0;
  logic ex_valid = 0, ex_taken = 0, ex_pred_hit = 0, btb_wr_block = 0;
  logic [31:0] ex_pc = 0, ex_target = 0, ex_pred_pc = 0;
  logic ex_ready, btb_load, redirect;
  logic [31:0] btb_pc, btb_target, redirect_pc;
`ifdef BTB_STATS_EN
  logic [31:0] branch_count, mispredict_count;
`endif
  int total = 0, bad = 0;
  ent_t q[$];
  bit m_armed = 0, m_rv = 0;
  logic [31:0] m_rpc = 0, m_bc = 0, m_mc = 0;

  btb_update_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_taken(ex_taken), .ex_pred_hit(ex_pred_hit), .ex_pred_pc(ex_pred_pc), .ex_ready(ex_ready),
    .btb_wr_block(btb_wr_block), .btb_load(btb_load), .btb_pc(btb_pc), .btb_target(btb_target),
    .redirect(redirect),
`ifdef BTB_STATS_EN
    .branch_count(branch_count), .mispredict_count(mispredict_count),
`endif
    .redirect_pc(redirect_pc));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_armed = 0; m_rv = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
  endtask

  task automatic check_outs();
    bit ld;
    ld = m_armed && !btb_wr_block;
    chk("ex_ready", 32'(ex_ready), 32'(q.size() < DEPTH));
    chk("btb_load", 32'(btb_load), 32'(ld));
    chk("btb_pc", btb_pc, ld ? q[0].pc : 32'h0);
    chk("btb_target", btb_target, ld ? q[0].tgt : 32'h0);
    chk("redirect", 32'(redirect), 32'(m_rv));
    chk("redirect_pc", redirect_pc, m_rpc);
`ifdef BTB_STATS_EN
    chk("branch_count", branch_count, m_bc);
    chk("mispredict_count", mispredict_count, m_mc);
`endif
  endtask

  // Called just after a negedge: drive, check, advance the model across the next posedge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                      input logic tk, input logic hit, input logic [31:0] ppc, input logic blk);
    bit ld, acc, mis, found;
    ex_valid = v; ex_pc = pc; ex_target = tgt; ex_taken = tk; ex_pred_hit = hit;
    ex_pred_pc = ppc; btb_wr_block = blk;
    #1;
    check_outs();
    ld  = m_armed && !blk;
    acc = v && (q.size() < DEPTH);
    mis = tk ? (!hit || ppc != tgt) : hit;
    if (ld) void'(q.pop_front());
    if (acc && tk && mis) begin
      found = 0;
      foreach (q[i]) if (q[i].pc == pc) begin q[i].tgt = tgt; found = 1; end
      if (!found) q.push_back('{pc, tgt});
    end
    m_rv  = acc && mis;
    m_rpc = !m_rv ? 32'h0 : tk ? tgt : pc + 32'd4;
    m_armed = q.size() != 0 && !blk;
    if (acc && m_bc != 32'hffff_ffff) m_bc++;
    if (acc && mis && m_mc != 32'hffff_ffff) m_mc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic blk);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, blk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    #1 check_outs();
    @(negedge clk);
    rst_n = 1;
    // taken miss, no BTB hit: redirect then write 0x100->0x200
    step(1, 32'h100, 32'h200, 1, 0, 0, 0);
    idle(3, 0);
    // not taken but predicted hit: redirect to pc+4, no write
    step(1, 32'h300, 32'h380, 0, 1, 32'h380, 0);
    idle(2, 0);
    // correct prediction: nothing
    step(1, 32'h340, 32'h480, 1, 1, 32'h480, 0);
    idle(1, 0);
    // fill while blocked, 5th refused, then drain in order
    for (int i = 0; i < 5; i++) step(1, 32'h1000 + 32'(i) * 16, 32'h2000 + 32'(i) * 16, 1, 0, 0, 1);
    idle(2, 1);
    idle(6, 0);
    // coalescing of same PC while blocked
    step(1, 32'h400, 32'h500, 1, 0, 0, 1);
    step(1, 32'h400, 32'h600, 1, 1, 32'h500, 1);
    idle(1, 1);
    idle(3, 0);
    // reset mid-drain with 3 entries
    for (int i = 0; i < 3; i++) step(1, 32'h700 + 32'(i) * 8, 32'h900 + 32'(i) * 8, 1, 0, 0, 1);
    idle(1, 0);
    step(1, 32'h7f0, 32'h9f0, 1, 0, 0, 0);
    #2 rst_n = 0;
    model_reset();
    #1 check_outs();
    @(negedge clk);
    rst_n = 1;
    idle(2, 0);
`ifdef BTB_STATS_EN
    // 10 resolutions, 3 of them mispredicts
    for (int i = 0; i < 10; i++)
      step(1, 32'h5000 + 32'(i) * 4, 32'h6000, 1, 1, (i < 3) ? 32'h0 : 32'h6000, 0);
    idle(2, 0);
    chk("stats_branch", branch_count, 32'd10);
    chk("stats_mispred", mispredict_count, 32'd3);
`endif
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc, tgt;
      logic tk, hit;
      pc  = 32'h8000 + 32'($urandom_range(0, 5)) * 4;
      tgt = 32'h0001_0000 + 32'($urandom_range(0, 255)) * 4;
      tk  = 1'($urandom_range(0, 1));
      hit = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 3) != 0), pc, tgt, tk, hit,
           ($urandom_range(0, 1) != 0) ? tgt : tgt + 32'd4, $urandom_range(0, 9) < 4);
    end
    idle(8, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
